mic_array_rx: RTL and testbench
===============================

// Module: mic_array_rx
// PURPOSE
//  Parametrised multi-mic I2S receiver, the successor to the single-mic i2s block.
//  Generates one shared BCLK/LRCLK pair for NUM_MICS SEL-grounded (left-slot) mics.
//  Deserialises all data lines in lock-step and presents one aligned multi-channel
//  sample per frame on a valid/ready interface. Feeds downstream DSP/mixing in audio_clk.
// PARAMETERS
//  NUM_MICS        3   number of mic data lines (1..8)
//  SAMPLE_WIDTH    16  bits kept per sample, MSB-first (1..24)
//  CLK_DIV         32  audio_clk cycles per BCLK period (even, >=4); 98.3MHz/32/64 = 48kHz
//  STARTUP_FRAMES  2   frames discarded after enable before samples are emitted (0..15)
// PORTS
//  clk_in          in   1                    audio_clk (98.3MHz)
//  rst_n_in        in   1                    async active-low reset
//  enable_in       in   1                    run receiver; sampled at frame boundaries
//  mic_data_in     in   NUM_MICS             I2S DOUT per mic, bit k = mic k
//  ready_in        in   1                    downstream accepts sample when high with valid
//  clr_overrun_in  in   1                    clears overrun_out
//  i2s_clk_out     out  1                    shared BCLK
//  lrcl_clk_out    out  1                    shared LRCLK/WS (low = left slot)
//  data_valid_out  out  1                    audio_out holds an unaccepted frame
//  audio_out       out  NUM_MICS*SAMPLE_WIDTH signed; mic k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//  overrun_out     out  1                    sticky: an unaccepted frame was overwritten
// BEHAVIOUR
//  Reset (async, rst_n_in=0): all outputs 0, counters 0, state IDLE. Mid-frame reset aborts frame.
//  States: IDLE -> SYNC -> RUN -> IDLE.
//   IDLE: div_cnt=bit_cnt=0, BCLK=LRCLK=0. enable_in=1 -> SYNC next cycle, frame_cnt=0.
//   SYNC: clocks run; captures discarded; at each frame end frame_cnt++; frame_cnt
//         reaching STARTUP_FRAMES at frame end -> RUN (STARTUP_FRAMES=0: IDLE -> RUN directly).
//   RUN: captures emitted once per frame.
//   In SYNC/RUN, enable_in=0 sampled at frame end -> IDLE; current frame always completes.
//  Clocking: div_cnt 0..CLK_DIV-1 wraps; BCLK=0 for div_cnt<CLK_DIV/2, else 1.
//   rise strobe: div_cnt==CLK_DIV/2-1 (BCLK rises next cycle). Wrap = BCLK falling edge.
//   bit_cnt 0..63 advances on div_cnt wrap. LRCLK = bit_cnt[5].
//   Frame end = bit_cnt==63 and div_cnt==CLK_DIV-1.
//  Capture: on rise strobe with bit_cnt in [1, SAMPLE_WIDTH], shift mic_data_in[k] into
//   shreg k (MSB first). bit_cnt 0 is the I2S delay slot.
//   Bits SAMPLE_WIDTH+1..63, and the whole right slot, are ignored.
//  Output: cycle after the strobe capturing bit SAMPLE_WIDTH, in RUN, load all shregs to
//   audio_out and set data_valid_out=1 (latency 1 clk from LSB strobe).
//   audio_out is stable while valid=1 and ready_in=0.
//   Handshake: transfer when valid & ready. valid drops next cycle unless a load occurs.
//   Load while valid=1 & ready_in=0: overwrite audio_out, valid stays 1, overrun_out<=1.
//   Load with ready_in=1 same cycle: no overrun, new data, valid stays 1.
//   overrun_out clears on clr_overrun_in. Set wins over clear when both occur the same cycle.
//   Returning to IDLE does not clear a pending valid sample.
//  Widths: div_cnt $clog2(CLK_DIV), bit_cnt 6b, frame_cnt 4b. Samples pass through
//   untruncated except for dropping mic LSBs beyond SAMPLE_WIDTH; no sign manipulation.
// TESTING
//  1 Reset, enable=0 for 500 clks -> BCLK=LRCLK=0, valid=0, all outputs 0.
//  2 Defaults, enable=1, mic models drive 0x8001/0x1234/0x7FFE, ready=1
//    -> BCLK period 32 clks, LRCLK period 2048 clks.
//    -> first valid after exactly 2 discarded frames; audio_out={0x7FFE,0x1234,0x8001}.
//  3 ready=0 across 2 frames -> valid held; audio_out = 2nd frame value; overrun_out=1.
//    clr_overrun_in pulse -> overrun_out=0.
//  4 Load coincident with ready=1 -> no overrun; new value present; valid stays 1.
//  5 enable dropped at bit_cnt 10 -> frame completes; LRCLK ends low; IDLE at frame end.
//    Re-enable -> STARTUP_FRAMES discarded again.
//  6 NUM_MICS=1, SAMPLE_WIDTH=24, CLK_DIV=4, mic drives 0xA5A5A5; rst_n_in pulsed mid-frame
//    -> outputs 0 immediately, no partial sample emitted.
//    -> after re-enable, audio_out=0xA5A5A5.

Source files
------------

// File: rtl/mic_array_rx.sv
// rtl/mic_array_rx.sv - multi-mic I2S receiver with shared BCLK/LRCLK and one aligned multi-channel sample per frame
module mic_array_rx #(
    parameter int NUM_MICS       = 3,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int CLK_DIV        = 32,
    parameter int STARTUP_FRAMES = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             enable_in,
    input  logic [NUM_MICS-1:0]              mic_data_in,
    input  logic                             ready_in,
    input  logic                             clr_overrun_in,
    output logic                             i2s_clk_out,
    output logic                             lrcl_clk_out,
    output logic                             data_valid_out,
    output logic [NUM_MICS*SAMPLE_WIDTH-1:0] audio_out,
    output logic                             overrun_out
);
    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam int              AW       = NUM_MICS * SAMPLE_WIDTH;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [5:0]       LSB_BIT  = 6'(SAMPLE_WIDTH);
    localparam logic [3:0]       SF       = 4'(STARTUP_FRAMES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        frame_cnt_q, frame_cnt_d;
    logic [AW-1:0]     shreg_q, shreg_d;
    logic [AW-1:0]     audio_q, audio_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;

    logic              running;
    logic              rise;
    logic              wrap;
    logic              frame_end;
    logic              capture;
    logic              load;
    logic              overrun_set;
    logic [SAMPLE_WIDTH:0] shift_tmp;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable_in) state_d = (SF == 4'd0) ? RUN : SYNC;
            SYNC: begin
                if (frame_end) begin
                    if (!enable_in)                      state_d = IDLE;
                    else if (frame_cnt_q + 4'd1 == SF)   state_d = RUN;
                end
            end
            RUN:     if (frame_end && !enable_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running   = (state_q != IDLE);
        rise      = running && (div_cnt_q == DIV_RISE);
        wrap      = running && (div_cnt_q == DIV_MAX);
        frame_end = wrap && (bit_cnt_q == 6'd63);
        // bit 0 of the left slot is the I2S delay slot, so the MSB lands on bit 1
        capture   = rise && (bit_cnt_q >= 6'd1) && (bit_cnt_q <= LSB_BIT);
        load      = capture && (bit_cnt_q == LSB_BIT) && (state_q == RUN);
    end

    always_comb begin
        div_cnt_d   = '0;
        bit_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q;
        if (!running) begin
            frame_cnt_d = 4'd0;
        end else begin
            div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
            bit_cnt_d = wrap ? bit_cnt_q + 6'd1 : bit_cnt_q;
            if (frame_end && (state_q == SYNC)) frame_cnt_d = frame_cnt_q + 4'd1;
        end
        // registered so the pins never glitch on counter decode
        bclk_d  = (div_cnt_d >= DIV_HALF);
        lrclk_d = bit_cnt_d[5];
    end

    always_comb begin
        shreg_d   = shreg_q;
        shift_tmp = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            shift_tmp = {shreg_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH], mic_data_in[k]};
            if (capture) shreg_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = shift_tmp[SAMPLE_WIDTH-1:0];
        end
    end

    always_comb begin
        audio_d     = load ? shreg_d : audio_q;
        valid_d     = valid_q;
        if (valid_q && ready_in) valid_d = 1'b0;
        if (load)                valid_d = 1'b1;
        overrun_set = load && valid_q && !ready_in;
        if (overrun_set)         overrun_d = 1'b1;
        else if (clr_overrun_in) overrun_d = 1'b0;
        else                     overrun_d = overrun_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            shreg_q     <= '0;
            audio_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            shreg_q     <= shreg_d;
            audio_q     <= audio_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
        end
    end

    assign i2s_clk_out    = bclk_q;
    assign lrcl_clk_out   = lrclk_q;
    assign data_valid_out = valid_q;
    assign audio_out      = audio_q;
    assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_mic_array_rx.sv
// tb/tb_mic_array_rx.sv - bench for mic_array_rx: 3-mic default instance plus 1-mic 24-bit fast-clock instance
module tb_mic_array_rx;
    localparam int DIV_A   = 32;
    localparam int SW_A    = 16;
    localparam int SF_A    = 2;
    localparam int FRAME_A = 64 * DIV_A;
    localparam int LAT_A   = SF_A * FRAME_A + SW_A * DIV_A + DIV_A / 2 + 1;
    localparam int DIV_B   = 4;
    localparam int SW_B    = 24;
    localparam int SF_B    = 2;
    localparam int FRAME_B = 64 * DIV_B;
    localparam int LAT_B   = SF_B * FRAME_B + SW_B * DIV_B + DIV_B / 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, enable_a, ready_a, clr_a;
    logic [2:0]  mic_a;
    logic        bclk_a, lrclk_a, valid_a, overrun_a;
    logic [47:0] audio_a;
    logic        rst_n_b, enable_b, ready_b, clr_b;
    logic [0:0]  mic_b;
    logic        bclk_b, lrclk_b, valid_b, overrun_b;
    logic [23:0] audio_b;

    mic_array_rx dut_a (
        .clk_in(clk), .rst_n_in(rst_n_a), .enable_in(enable_a), .mic_data_in(mic_a),
        .ready_in(ready_a), .clr_overrun_in(clr_a), .i2s_clk_out(bclk_a),
        .lrcl_clk_out(lrclk_a), .data_valid_out(valid_a), .audio_out(audio_a),
        .overrun_out(overrun_a)
    );

    mic_array_rx #(.NUM_MICS(1), .SAMPLE_WIDTH(24), .CLK_DIV(4), .STARTUP_FRAMES(2)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n_b), .enable_in(enable_b), .mic_data_in(mic_b),
        .ready_in(ready_b), .clr_overrun_in(clr_b), .i2s_clk_out(bclk_b),
        .lrcl_clk_out(lrclk_b), .data_valid_out(valid_b), .audio_out(audio_b),
        .overrun_out(overrun_b)
    );

    typedef struct {
        logic [23:0] m0;
        logic [23:0] m1;
        logic [23:0] m2;
        logic [47:0] exp;
    } vec_t;
    vec_t tbl [9];

    int checks = 0;
    int failures = 0;
    logic [47:0] qa [$];
    logic [23:0] qb [$];
    int hs_a = 0;
    int hs_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // I2S mic models: 24-bit words, MSB on the first falling BCLK after the delay slot
    logic [23:0] word_a [3];
    logic [23:0] sh_a [3];
    int          idx_a = 0;
    always @(negedge bclk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            idx_a = 0;
            mic_a = '0;
        end else begin
            idx_a = lrclk_a ? -1 : idx_a + 1;
            if (idx_a == 1) for (int k = 0; k < 3; k++) sh_a[k] = word_a[k];
            for (int k = 0; k < 3; k++)
                mic_a[k] = (idx_a >= 1 && idx_a <= 24) ? sh_a[k][24 - idx_a] : 1'b0;
        end
    end

    logic [23:0] word_b;
    logic [23:0] sh_b;
    int          idx_b = 0;
    always @(negedge bclk_b or negedge rst_n_b) begin
        if (!rst_n_b) begin
            idx_b = 0;
            mic_b = '0;
        end else begin
            idx_b = lrclk_b ? -1 : idx_b + 1;
            if (idx_b == 1) sh_b = word_b;
            mic_b[0] = (idx_b >= 1 && idx_b <= 24) ? sh_b[24 - idx_b] : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            hs_a++;
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL sample_a: got unexpected %0h expected none", audio_a);
            end else begin
                check("sample_a", audio_a, qa.pop_front());
            end
        end
        if (valid_b && ready_b) begin
            hs_b++;
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL sample_b: got unexpected %0h expected none", audio_b);
            end else begin
                check("sample_b", audio_b, qb.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_words_a(input int i);
        word_a[0] = tbl[i].m0;
        word_a[1] = tbl[i].m1;
        word_a[2] = tbl[i].m2;
    endtask

    task automatic wait_first_valid(input bit sel_b, input int bound,
                                    output int lat, output int bper, output int lper);
        int   n = 0;
        int   br0 = -1, br1 = -1, lr0 = -1, lr1 = -1;
        logic pb, pl, b, l, v;
        pb  = sel_b ? bclk_b : bclk_a;
        pl  = sel_b ? lrclk_b : lrclk_a;
        lat = -1;
        while (n < bound) begin
            step(1);
            n++;
            b = sel_b ? bclk_b : bclk_a;
            l = sel_b ? lrclk_b : lrclk_a;
            v = sel_b ? valid_b : valid_a;
            if (b && !pb) begin
                if (br0 < 0) br0 = n;
                else if (br1 < 0) br1 = n;
            end
            if (l && !pl) begin
                if (lr0 < 0) lr0 = n;
                else if (lr1 < 0) lr1 = n;
            end
            pb = b;
            pl = l;
            if (v) begin
                lat = n;
                break;
            end
        end
        bper = br1 - br0;
        lper = lr1 - lr0;
    endtask

    task automatic wait_hs(input bit sel_b, input int target, input int bound, input string name);
        int n = 0;
        while (((sel_b ? hs_b : hs_a) < target) && n < bound) begin
            step(1);
            n++;
        end
        check(name, sel_b ? hs_b : hs_a, target);
    endtask

    initial begin
        int   lat, bper, lper, n;
        logic quiet_a, quiet_b;

        tbl[0] = '{24'h800100, 24'h123400, 24'h7FFE00, 48'h7FFE_1234_8001};
        tbl[1] = '{24'hFFFFFF, 24'h000001, 24'hA5A57F, 48'hA5A5_0000_FFFF};
        tbl[2] = '{24'h000180, 24'h800000, 24'h5A5AC3, 48'h5A5A_8000_0001};
        tbl[3] = '{24'h13579B, 24'h2468AC, 24'h9BDF11, 48'h9BDF_2468_1357};
        tbl[4] = '{24'h0F0F00, 24'hF0F000, 24'h3C3C00, 48'h3C3C_F0F0_0F0F};
        tbl[5] = '{24'h111122, 24'h333344, 24'h555566, 48'h5555_3333_1111};
        tbl[6] = '{24'hCAFE01, 24'hBEEF02, 24'hDEAD03, 48'hDEAD_BEEF_CAFE};
        tbl[7] = '{24'h777700, 24'h888800, 24'h999900, 48'h9999_8888_7777};
        tbl[8] = '{24'h0102FF, 24'h0304FF, 24'h0506FF, 48'h0506_0304_0102};

        rst_n_a = 1'b0; enable_a = 1'b0; ready_a = 1'b1; clr_a = 1'b0;
        rst_n_b = 1'b0; enable_b = 1'b0; ready_b = 1'b1; clr_b = 1'b0;
        set_words_a(0);
        word_b = 24'h123456;
        step(3);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        quiet_a = 1'b1;
        quiet_b = 1'b1;
        repeat (500) begin
            step(1);
            if (bclk_a || lrclk_a || valid_a || overrun_a || (audio_a != '0)) quiet_a = 1'b0;
            if (bclk_b || lrclk_b || valid_b || overrun_b || (audio_b != '0)) quiet_b = 1'b0;
        end
        check("disabled_quiet_a", quiet_a, 1'b1);
        check("disabled_quiet_b", quiet_b, 1'b1);

        qa.push_back(tbl[0].exp);
        enable_a = 1'b1;
        wait_first_valid(1'b0, 3 * LAT_A, lat, bper, lper);
        check("first_valid_latency_a", lat, LAT_A);
        check("bclk_period_a", bper, DIV_A);
        check("lrclk_period_a", lper, FRAME_A);
        check("overrun_idle_a", overrun_a, 1'b0);
        wait_hs(1'b0, 1, 100, "hs_vec0");
        for (int i = 1; i < 4; i++) begin
            set_words_a(i);
            qa.push_back(tbl[i].exp);
            wait_hs(1'b0, i + 1, FRAME_A + 200, $sformatf("hs_vec%0d", i));
        end

        ready_a = 1'b0;
        set_words_a(4);
        n = 0;
        while (!valid_a && n < FRAME_A + 200) begin
            step(1);
            n++;
        end
        check("held_valid_a", valid_a, 1'b1);
        check("held_audio_first_a", audio_a, tbl[4].exp);
        check("no_overrun_first_load_a", overrun_a, 1'b0);
        set_words_a(5);
        step(FRAME_A);
        check("overwrite_valid_a", valid_a, 1'b1);
        check("overwrite_audio_a", audio_a, tbl[5].exp);
        check("overrun_set_a", overrun_a, 1'b1);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        check("overrun_cleared_a", overrun_a, 1'b0);
        check("audio_stable_a", audio_a, tbl[5].exp);

        set_words_a(6);
        step(FRAME_A - 2);
        qa.push_back(tbl[5].exp);
        qa.push_back(tbl[6].exp);
        ready_a = 1'b1;
        step(1);
        check("coincident_valid_a", valid_a, 1'b1);
        check("coincident_audio_a", audio_a, tbl[6].exp);
        check("coincident_no_overrun_a", overrun_a, 1'b0);
        wait_hs(1'b0, 6, 100, "hs_coincident");

        set_words_a(7);
        qa.push_back(tbl[7].exp);
        step(1839);
        enable_a = 1'b0;
        step(1727);
        check("last_bit_lrclk_a", lrclk_a, 1'b1);
        check("last_bit_bclk_a", bclk_a, 1'b1);
        step(1);
        check("idle_lrclk_a", lrclk_a, 1'b0);
        check("idle_bclk_a", bclk_a, 1'b0);
        check("hs_final_frame", hs_a, 7);
        quiet_a = 1'b1;
        repeat (200) begin
            step(1);
            if (bclk_a || lrclk_a || valid_a) quiet_a = 1'b0;
        end
        check("idle_quiet_a", quiet_a, 1'b1);

        set_words_a(8);
        qa.push_back(tbl[8].exp);
        enable_a = 1'b1;
        wait_first_valid(1'b0, 3 * LAT_A, lat, bper, lper);
        check("reenable_latency_a", lat, LAT_A);
        wait_hs(1'b0, 8, 100, "hs_reenable");
        enable_a = 1'b0;

        qb.push_back(24'h123456);
        enable_b = 1'b1;
        wait_first_valid(1'b1, 3 * LAT_B, lat, bper, lper);
        check("first_valid_latency_b", lat, LAT_B);
        check("bclk_period_b", bper, DIV_B);
        check("lrclk_period_b", lper, FRAME_B);
        wait_hs(1'b1, 1, 100, "hs_b_first");
        step(200);
        word_b = 24'hA5A5A5;
        rst_n_b = 1'b0;
        #1;
        check("reset_outputs_b", {bclk_b, lrclk_b, valid_b, overrun_b, audio_b}, 28'h0);
        enable_b = 1'b0;
        step(3);
        rst_n_b = 1'b1;
        quiet_b = 1'b1;
        repeat (300) begin
            step(1);
            if (valid_b || (audio_b != '0)) quiet_b = 1'b0;
        end
        check("no_partial_sample_b", quiet_b, 1'b1);
        qb.push_back(24'hA5A5A5);
        enable_b = 1'b1;
        wait_first_valid(1'b1, 3 * LAT_B, lat, bper, lper);
        check("reenable_latency_b", lat, LAT_B);
        wait_hs(1'b1, 2, 100, "hs_b_reenable");

        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
